// File: rtl/osc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : osc_pkg
//  Description : Shared types and helpers for the multi-channel oscillator.
//  Revision    : 1.0  initial release
// ============================================================================
package osc_pkg;

    // Waveform select encoding, matches the cfg_sel bus field
    typedef enum logic [1:0] {
        SINE  = 2'b00,
        SAW   = 2'b01,
        PULSE = 2'b10,
        TRI   = 2'b11
    } wave_sel_t;

    // Sequencer states
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } osc_state_t;

    // Full-scale magnitude M = 2^(out_w-1)
    function automatic longint osc_m(input int out_w);
        return longint'(1) << (out_w - 1);
    endfunction

    // Quarter-scale magnitude Q = 2^(out_w-2), used by the triangle
    function automatic longint osc_q(input int out_w);
        return longint'(1) << (out_w - 2);
    endfunction

    // Channel index width, kept at least one bit for a single channel
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multi_wave_osc_if.sv
`default_nettype none
// ============================================================================
//  Module      : multi_wave_osc_if
//  Description : Tick, configuration, sine LUT and sample-output bundle.
//  Revision    : 1.0  initial release
// ============================================================================
interface multi_wave_osc_if #(
    parameter int NUM_CH  = 4,
    parameter int PHASE_W = 24,
    parameter int IDX_W   = 12,
    parameter int OUT_W   = 24
);
    localparam int c_ch_w = osc_pkg::ch_width(NUM_CH);

    logic                     sample_tick;
    logic                     cfg_we;
    logic [c_ch_w-1:0]        cfg_ch;
    logic [PHASE_W-1:0]       cfg_incr;
    logic [1:0]               cfg_sel;
    logic [IDX_W-1:0]         cfg_duty;
    logic                     cfg_sync;
    logic [IDX_W-1:0]         sine_addr;
    logic signed [OUT_W-1:0]  sine_data;
    logic                     out_valid;
    logic [c_ch_w-1:0]        out_ch;
    logic signed [OUT_W-1:0]  out_sample;
    logic                     busy;
    logic                     overrun;

    // Oscillator side
    modport slave (
        input  sample_tick, cfg_we, cfg_ch, cfg_incr, cfg_sel, cfg_duty,
               cfg_sync, sine_data,
        output sine_addr, out_valid, out_ch, out_sample, busy, overrun
    );

    // Controller / environment side
    modport master (
        output sample_tick, cfg_we, cfg_ch, cfg_incr, cfg_sel, cfg_duty,
               cfg_sync, sine_data,
        input  sine_addr, out_valid, out_ch, out_sample, busy, overrun
    );

endinterface
`default_nettype wire

// File: rtl/osc_shape.sv
`default_nettype none
// ============================================================================
//  Module      : osc_shape
//  Description : Combinational waveform former: idx/sel/duty/sine -> sample.
//  Revision    : 1.0  initial release
// ============================================================================
module osc_shape
    import osc_pkg::*;
#(
    parameter int IDX_W = 12,
    parameter int OUT_W = 24
) (
    input  logic [IDX_W-1:0]        i_idx,
    input  wave_sel_t               i_sel,
    input  logic [IDX_W-1:0]        i_duty,
    input  logic signed [OUT_W-1:0] i_sine,
    output logic signed [OUT_W-1:0] o_sample
);

    // M as a bit pattern doubles as -M in two's complement
    localparam logic [OUT_W-1:0] c_m     = OUT_W'(osc_m(OUT_W));
    localparam logic [OUT_W-1:0] c_m_m1  = OUT_W'(osc_m(OUT_W) - 1);
    localparam logic [OUT_W-1:0] c_q     = OUT_W'(osc_q(OUT_W));

    logic [OUT_W-1:0] w_saw_u;
    logic [OUT_W-1:0] w_tri_r;

    // idx placed just below the sign bit gives the unsigned ramp
    assign w_saw_u = OUT_W'(i_idx) << (OUT_W - 1 - IDX_W);
    // idx without its MSB, left-aligned one bit lower: ramp over half a period
    assign w_tri_r = OUT_W'(i_idx[IDX_W-2:0]) << (OUT_W - IDX_W);

    // Select the waveform; all arithmetic wraps at OUT_W bits
    always_comb begin
        o_sample = '0;
        case (i_sel)
            SINE:  o_sample = i_sine;
            SAW:   o_sample = $signed(w_saw_u - c_m);
            PULSE: o_sample = (i_idx < i_duty) ? $signed(c_m_m1) : $signed(c_m);
            TRI:   o_sample = i_idx[IDX_W-1] ? $signed(c_q - w_tri_r)
                                             : $signed(w_tri_r - c_q);
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multi_wave_osc.sv
`default_nettype none
// ============================================================================
//  Module      : multi_wave_osc
//  Description : Time-multiplexed multi-channel oscillator (sine via external
//                LUT, saw/pulse/triangle internal) with wrap-deferred
//                waveform changes.
//  Revision    : 1.0  initial release
// ============================================================================
module multi_wave_osc
    import osc_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int PHASE_W = 24,
    parameter int IDX_W   = 12,
    parameter int OUT_W   = 24
) (
    input  logic           clk,
    input  logic           rst_n,
    multi_wave_osc_if.slave bus
);

    localparam int                  c_ch_w     = ch_width(NUM_CH);
    localparam logic [c_ch_w-1:0]   c_last_ch  = c_ch_w'(NUM_CH - 1);
    localparam logic [IDX_W-1:0]    c_duty_rst = {1'b1, {(IDX_W-1){1'b0}}};

    // ---------------- per-channel state ----------------
    logic [PHASE_W-1:0] r_phase    [NUM_CH];
    logic [PHASE_W-1:0] r_incr     [NUM_CH];
    wave_sel_t          r_sel_act  [NUM_CH];
    wave_sel_t          r_sel_shd  [NUM_CH];
    logic [IDX_W-1:0]   r_duty_act [NUM_CH];
    logic [IDX_W-1:0]   r_duty_shd [NUM_CH];

    // ---------------- sequencer ----------------
    osc_state_t         r_state;
    osc_state_t         w_state_nxt;
    logic [c_ch_w-1:0]  r_cnt;
    logic               r_issuing;
    logic               w_issue;
    logic               w_start;
    logic               w_set_ovr;
    logic [c_ch_w-1:0]  w_issue_ch;
    logic               r_overrun;

    // ---------------- pipeline ----------------
    logic [PHASE_W:0]        w_sum;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_cfg_hit;
    logic [IDX_W-1:0]        r_sine_addr;
    logic                    r_s1_valid;
    logic [c_ch_w-1:0]       r_s1_ch;
    logic [IDX_W-1:0]        r_s1_idx;
    wave_sel_t               r_s1_sel;
    logic [IDX_W-1:0]        r_s1_duty;
    logic                    r_s2_valid;
    logic [c_ch_w-1:0]       r_s2_ch;
    logic [IDX_W-1:0]        r_s2_idx;
    wave_sel_t               r_s2_sel;
    logic [IDX_W-1:0]        r_s2_duty;
    logic signed [OUT_W-1:0] w_shape;
    logic                    r_out_valid;
    logic [c_ch_w-1:0]       r_out_ch;
    logic signed [OUT_W-1:0] r_out_sample;

    // Phase read and advance for the channel being issued
    assign w_idx     = r_phase[w_issue_ch][PHASE_W-1 -: IDX_W];
    assign w_sum     = {1'b0, r_phase[w_issue_ch]} + {1'b0, r_incr[w_issue_ch]};
    assign w_cfg_hit = bus.cfg_we && (int'(bus.cfg_ch) < NUM_CH);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state and issue control; the tick itself issues channel 0
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_issue_ch  = r_cnt;
        w_start     = 1'b0;
        w_set_ovr   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.sample_tick) begin
                    w_state_nxt = RUN;
                    w_start     = 1'b1;
                    w_issue     = 1'b1;
                    w_issue_ch  = '0;
                end
            end
            RUN: begin
                w_issue   = r_issuing;
                w_set_ovr = bus.sample_tick;
                if (r_out_valid && (r_out_ch == c_last_ch))
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Channel counter: next channel to issue after channel 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_issuing <= 1'b0;
        end else if (w_start) begin
            r_cnt     <= (NUM_CH > 1) ? c_ch_w'(1) : '0;
            r_issuing <= (NUM_CH > 1);
        end else if (w_issue) begin
            if (r_cnt == c_last_ch) r_issuing <= 1'b0;
            else                    r_cnt     <= r_cnt + c_ch_w'(1);
        end
    end

    // Sticky overrun on a tick arriving mid-sequence
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_overrun <= 1'b0;
        else if (w_set_ovr) r_overrun <= 1'b1;
    end

    // Per-channel state; a config write is ordered after the advance so it wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_phase[i]    <= '0;
                r_incr[i]     <= '0;
                r_sel_act[i]  <= SINE;
                r_sel_shd[i]  <= SINE;
                r_duty_act[i] <= c_duty_rst;
                r_duty_shd[i] <= c_duty_rst;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_issue && (int'(w_issue_ch) == i)) begin
                    r_phase[i] <= w_sum[PHASE_W-1:0];
                    if (w_sum[PHASE_W]) begin
                        r_sel_act[i]  <= r_sel_shd[i];
                        r_duty_act[i] <= r_duty_shd[i];
                    end
                end
                if (w_cfg_hit && (int'(bus.cfg_ch) == i)) begin
                    r_incr[i]     <= bus.cfg_incr;
                    r_sel_shd[i]  <= wave_sel_t'(bus.cfg_sel);
                    r_duty_shd[i] <= bus.cfg_duty;
                    if (bus.cfg_sync) begin
                        r_phase[i]    <= '0;
                        r_sel_act[i]  <= wave_sel_t'(bus.cfg_sel);
                        r_duty_act[i] <= bus.cfg_duty;
                    end
                end
            end
        end
    end

    // Issue stage: LUT address plus the pre-advance active settings
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_sine_addr <= '0;
            r_s1_ch     <= '0;
            r_s1_idx    <= '0;
            r_s1_sel    <= SINE;
            r_s1_duty   <= '0;
        end else begin
            r_s1_valid <= w_issue;
            if (w_issue) begin
                r_sine_addr <= w_idx;
                r_s1_ch     <= w_issue_ch;
                r_s1_idx    <= w_idx;
                r_s1_sel    <= r_sel_act[w_issue_ch];
                r_s1_duty   <= r_duty_act[w_issue_ch];
            end
        end
    end

    // Wait stage covering the LUT's one-cycle read latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_ch    <= '0;
            r_s2_idx   <= '0;
            r_s2_sel   <= SINE;
            r_s2_duty  <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_ch    <= r_s1_ch;
            r_s2_idx   <= r_s1_idx;
            r_s2_sel   <= r_s1_sel;
            r_s2_duty  <= r_s1_duty;
        end
    end

    osc_shape #(
        .IDX_W (IDX_W),
        .OUT_W (OUT_W)
    ) u_shape (
        .i_idx    (r_s2_idx),
        .i_sel    (r_s2_sel),
        .i_duty   (r_s2_duty),
        .i_sine   (bus.sine_data),
        .o_sample (w_shape)
    );

    // Output register; sample and channel hold between strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_ch     <= '0;
            r_out_sample <= '0;
        end else begin
            r_out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_out_ch     <= r_s2_ch;
                r_out_sample <= w_shape;
            end
        end
    end

    assign bus.sine_addr  = r_sine_addr;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_ch     = r_out_ch;
    assign bus.out_sample = r_out_sample;
    assign bus.busy       = (r_state == RUN);
    assign bus.overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_multi_wave_osc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multi_wave_osc
//  Description : Directed self-checking bench for multi_wave_osc.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multi_wave_osc;

    localparam int NUM_CH  = 4;
    localparam int PHASE_W = 24;
    localparam int IDX_W   = 12;
    localparam int OUT_W   = 24;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_errors;

    longint q_smp[$];
    int     q_ch[$];
    int     q_cyc[$];
    int     busy_first;
    int     busy_last;
    int     t;

    multi_wave_osc_if #(
        .NUM_CH (NUM_CH), .PHASE_W (PHASE_W), .IDX_W (IDX_W), .OUT_W (OUT_W)
    ) ifc ();

    multi_wave_osc #(
        .NUM_CH (NUM_CH), .PHASE_W (PHASE_W), .IDX_W (IDX_W), .OUT_W (OUT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: a value seen at a falling edge belongs to cycle cyc+1
    always @(posedge clk) cyc <= cyc + 1;

    // Sine LUT model with one-cycle latency, returns {idx, 12'h0}
    always @(posedge clk) ifc.sine_data <= {ifc.sine_addr, 12'h000};

    // Output and busy monitor
    always @(negedge clk) begin
        if (ifc.out_valid) begin
            q_smp.push_back(longint'(ifc.out_sample));
            q_ch.push_back(int'(ifc.out_ch));
            q_cyc.push_back(cyc + 1);
        end
        if (ifc.busy) begin
            if (busy_first < 0) busy_first = cyc + 1;
            busy_last = cyc + 1;
        end
    end

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint smp_of(input int ch);
        foreach (q_ch[k]) if (q_ch[k] == ch) return q_smp[k];
        return 64'sh7FFF_FFFF_FFFF_FFFF;
    endfunction

    function automatic longint saw_of(input int idx);
        return (longint'(idx) << 11) - 64'sd8388608;
    endfunction

    task automatic clear_mon();
        q_smp.delete();
        q_ch.delete();
        q_cyc.delete();
        busy_first = -1;
        busy_last  = -1;
    endtask

    task automatic cfg_write(input int ch, input logic [23:0] incr,
                             input logic [1:0] sel, input logic [11:0] duty,
                             input logic sync);
        @(negedge clk);
        ifc.cfg_we   = 1'b1;
        ifc.cfg_ch   = 2'(ch);
        ifc.cfg_incr = incr;
        ifc.cfg_sel  = sel;
        ifc.cfg_duty = duty;
        ifc.cfg_sync = sync;
        @(negedge clk);
        ifc.cfg_we   = 1'b0;
        ifc.cfg_sync = 1'b0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 30 && ifc.busy; n++) @(negedge clk);
        check_eq("idle_reached", longint'(ifc.busy), 0);
        @(negedge clk);
    endtask

    // One tick, return the tick edge number, collect the whole sequence
    task automatic run_tick(output int tt);
        clear_mon();
        @(negedge clk);
        ifc.sample_tick = 1'b1;
        tt = cyc + 1;
        @(negedge clk);
        ifc.sample_tick = 1'b0;
        wait_idle();
        check_eq("pulse_count", q_smp.size(), NUM_CH);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        ifc.sample_tick = 1'b0;
        ifc.cfg_we      = 1'b0;
        ifc.cfg_ch      = '0;
        ifc.cfg_incr    = '0;
        ifc.cfg_sel     = '0;
        ifc.cfg_duty    = '0;
        ifc.cfg_sync    = 1'b0;
        clear_mon();

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_out_valid", longint'(ifc.out_valid), 0);
        check_eq("rst_out_sample", longint'(ifc.out_sample), 0);
        check_eq("rst_busy", longint'(ifc.busy), 0);
        check_eq("rst_overrun", longint'(ifc.overrun), 0);
        check_eq("rst_sine_addr", longint'(ifc.sine_addr), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Saw on ch0 plus strobe and busy timing
        cfg_write(0, 24'h001000, 2'b01, 12'h800, 1'b1);
        run_tick(t);
        check_eq("saw_tick1", smp_of(0), -64'sd8388608);
        check_eq("ch3_sine_idx0", smp_of(3), 0);
        check_eq("ch0_valid_cyc", q_cyc[0], t + 3);
        check_eq("ch0_order", q_ch[0], 0);
        check_eq("ch3_valid_cyc", q_cyc[3], t + 6);
        check_eq("ch3_order", q_ch[3], 3);
        check_eq("busy_first", busy_first, t + 1);
        check_eq("busy_last", busy_last, t + 6);
        run_tick(t);
        check_eq("saw_tick2", smp_of(0), -64'sd8386560);

        // Pulse on ch1, duty 0x400
        cfg_write(1, 24'h3FF000, 2'b10, 12'h400, 1'b1);
        run_tick(t);
        check_eq("pulse_idx000", smp_of(1), 64'sd8388607);
        cfg_write(1, 24'h001000, 2'b10, 12'h400, 1'b0);
        run_tick(t);
        check_eq("pulse_idx3ff", smp_of(1), 64'sd8388607);
        run_tick(t);
        check_eq("pulse_idx400", smp_of(1), -64'sd8388608);
        cfg_write(1, 24'h400000, 2'b10, 12'h000, 1'b1);
        run_tick(t);
        check_eq("pulse_duty0_a", smp_of(1), -64'sd8388608);
        run_tick(t);
        check_eq("pulse_duty0_b", smp_of(1), -64'sd8388608);

        // Triangle on ch2
        cfg_write(2, 24'h800000, 2'b11, 12'h800, 1'b1);
        run_tick(t);
        check_eq("tri_idx000", smp_of(2), -64'sd4194304);
        run_tick(t);
        check_eq("tri_idx800", smp_of(2), 64'sd4194304);
        cfg_write(2, 24'hFFF000, 2'b11, 12'h800, 1'b1);
        run_tick(t);
        check_eq("tri_idx000_b", smp_of(2), -64'sd4194304);
        run_tick(t);
        check_eq("tri_idxfff", smp_of(2), -64'sd4190208);

        // Deferred saw -> sine on ch1, then sync commits immediately
        cfg_write(1, 24'h900000, 2'b01, 12'h800, 1'b1);
        run_tick(t);
        check_eq("defer_saw_idx000", smp_of(1), -64'sd8388608);
        cfg_write(1, 24'h100000, 2'b00, 12'h800, 1'b0);
        for (int idx = 'h900; idx <= 'hF00; idx += 'h100) begin
            run_tick(t);
            check_eq($sformatf("defer_saw_idx%03h", idx), smp_of(1), saw_of(idx));
        end
        run_tick(t);
        check_eq("defer_sine_idx000", smp_of(1), 0);
        run_tick(t);
        check_eq("defer_sine_idx100", smp_of(1), 64'sd1048576);
        cfg_write(1, 24'h100000, 2'b01, 12'h800, 1'b1);
        run_tick(t);
        check_eq("sync_saw_idx000", smp_of(1), -64'sd8388608);

        // Overrun: second tick while busy
        check_eq("overrun_clear", longint'(ifc.overrun), 0);
        clear_mon();
        @(negedge clk);
        ifc.sample_tick = 1'b1;
        @(negedge clk);
        @(negedge clk);
        ifc.sample_tick = 1'b0;
        wait_idle();
        check_eq("overrun_pulses", q_smp.size(), NUM_CH);
        check_eq("overrun_set", longint'(ifc.overrun), 1);
        run_tick(t);
        check_eq("overrun_sticky", longint'(ifc.overrun), 1);

        // Reset mid-sequence
        clear_mon();
        @(negedge clk);
        ifc.sample_tick = 1'b1;
        @(negedge clk);
        ifc.sample_tick = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("midrst_out_valid", longint'(ifc.out_valid), 0);
        check_eq("midrst_out_sample", longint'(ifc.out_sample), 0);
        check_eq("midrst_out_ch", longint'(ifc.out_ch), 0);
        check_eq("midrst_busy", longint'(ifc.busy), 0);
        check_eq("midrst_overrun", longint'(ifc.overrun), 0);
        check_eq("midrst_sine_addr", longint'(ifc.sine_addr), 0);
        @(negedge clk);
        clear_mon();
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("midrst_no_stray_valid", q_smp.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/multi_wave_osc.md
# multi_wave_osc

Parametrised, time-multiplexed multi-channel oscillator for the FM synth voice path. Each channel has its own phase accumulator, increment, waveform select and pulse duty. All channels are processed in turn once per `sample_tick`. Sine samples come from an external single-port sine LUT with one-cycle read latency; saw, pulse and triangle are computed internally. Waveform changes are deferred to phase wrap so they never glitch mid-period.

## Interface
Parameters:
- `NUM_CH`, 4, number of channels (≥1)
- `PHASE_W`, 24, phase accumulator width
- `IDX_W`, 12, waveform index width, taken from the accumulator MSBs (≤ `PHASE_W`)
- `OUT_W`, 24, signed sample width (≥ `IDX_W`+2)

Ports:
- `clk`, in, 1, system clock
- `rst_n`, in, 1, asynchronous active-low reset
- `sample_tick`, in, 1, one-cycle pulse at the sample rate
- `cfg_we`, in, 1, configuration write strobe
- `cfg_ch`, in, $clog2(NUM_CH), channel addressed by the write
- `cfg_incr`, in, PHASE_W, phase increment
- `cfg_sel`, in, 2, waveform: 00 sine, 01 saw, 10 pulse, 11 triangle
- `cfg_duty`, in, IDX_W, pulse high threshold
- `cfg_sync`, in, 1, with `cfg_we`: clear the channel phase
- `sine_addr`, out, IDX_W, registered LUT address
- `sine_data`, in, OUT_W signed, LUT data, valid one cycle after `sine_addr`
- `out_valid`, out, 1, sample strobe
- `out_ch`, out, $clog2(NUM_CH), channel of the sample
- `out_sample`, out, OUT_W signed, sample value
- `busy`, out, 1, sequence in progress
- `overrun`, out, 1, sticky; cleared only by reset

## Operation
- Reset values: all phases 0, increments 0, active and shadow `sel` = sine, duty = 2^(IDX_W-1). All outputs are 0.
- FSM states: IDLE, RUN.
  - IDLE → RUN on `sample_tick`.
  - RUN steps channel 0 to NUM_CH-1, issuing one channel per cycle.
  - RUN → IDLE after the last `out_valid`.
- `sample_tick` while `busy`: the tick is ignored and `overrun` is set.
- Per channel, in pipeline order:
  - S1: idx = phase[PHASE_W-1 -: IDX_W]. Drive `sine_addr` = idx. phase ← phase + incr (mod 2^PHASE_W). On carry-out, the shadow sel/duty are copied to active.
  - S2: form the sample from idx using the active sel/duty captured in S1, then register `out_sample`, `out_ch` and `out_valid`.
- A sample always uses the phase held before advancing. A sel/duty change therefore first affects the sample after the wrap.
- Arithmetic, with M = 2^(OUT_W-1) and Q = 2^(OUT_W-2):
  - saw = {0, idx, 0…} − M, ranging from −M up to M − 2^(OUT_W-1-IDX_W).
  - pulse = (idx < duty) ? M−1 : −M. duty 0 gives a constant −M.
  - triangle: let r = {0, idx[IDX_W-2:0], 0…} at OUT_W bits. The result is r − Q when idx MSB = 0, and Q − r otherwise.
  - sine = `sine_data` passed unmodified.
- Config writes:
  - `cfg_incr` takes effect at the next S1 of that channel.
  - `cfg_sel` and `cfg_duty` go to shadow and commit at the next wrap.
  - `cfg_sync` clears the phase and commits the shadow values immediately.
  - If a write coincides with the S1 of the same channel, S1 uses the old values and the write wins over the advance.
  - A write with an out-of-range `cfg_ch` is ignored.
- Reset mid-sequence aborts the sequence. No partial `out_valid` is issued after reset release.

## Timing
- `sample_tick` high at edge T:
  - channel c has `sine_addr` valid in cycle T+1+c;
  - `sine_data` is sampled at T+2+c;
  - `out_valid` is high in cycle T+3+c, for one cycle per channel.
- `busy` is high in cycles T+1 … T+2+NUM_CH.
- The earliest accepted next tick is the cycle after `busy` falls. Minimum tick period is NUM_CH+3 cycles.
- `out_sample` and `out_ch` hold their values while `out_valid` is low.

## Structure
- `osc_pkg` holds:
  - the `wave_sel_t` enum (SINE, SAW, PULSE, TRI);
  - the FSM state typedef;
  - the helper functions for M and Q.
- `osc_shape` is a combinational sub-module mapping idx, sel, duty and sine to a sample. It is instantiated once, in S2.
- Per-channel state is held in register arrays indexed by the channel counter.

## Test plan
Defaults unless noted: NUM_CH=4, PHASE_W=24, IDX_W=12, OUT_W=24. The LUT model returns {idx, 12'h0}.
- Reset: assert `rst_n`=0 mid-sequence → all outputs 0, `busy`=0. After release, no stray `out_valid`.
- Saw, ch0, incr 0x001000: first tick → −8388608; second tick → −8386560. `out_valid` for ch0 at T+3 and ch3 at T+6.
- Pulse, duty 0x400: idx 0x3FF → 8388607, idx 0x400 → −8388608. With duty 0 → always −8388608.
- Triangle: idx 0x000 → −4194304; idx 0x800 → 4194304; idx 0xFFF → −4190208 (= 4194304 − 8384512).
- Deferred commit: change ch1 saw→sine at idx 0x900, incr 0x100000 → saw continues until the wrap; the sample after the wrap is sine. `cfg_sync` → next sample idx 0, with the new sel applied immediately.
- Tick on the cycle after the first tick (while `busy`) → `overrun`=1, exactly 4 `out_valid` pulses. `overrun` remains set until reset.
